// File: rtl/tensor_host_sequencer.sv
// Host-side sequencer for the tiny tensor CPU: buffers a job, drives the burst instruction stream, returns results.
// Optional feature macro: TENSOR_HOST_RESET_PREAMBLE_EN (issues a CPU reset word before every burst write).
module tensor_host_sequencer #(
  parameter int OPERATE_WAIT = 8
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              job_valid_in,
  input  logic [2:0]        job_op_in,
  output logic              job_ready_out,
  input  logic              operand_valid_in,
  input  logic [7:0]        operand_data_in,
  output logic              operand_ready_out,
  output logic [15:0]       current_instruction_out,
  input  logic signed [7:0] cpu_output_in,
  output logic              result_valid_out,
  output logic [7:0]        result_data_out,
  input  logic              result_ready_in,
  output logic              busy_out
);

  localparam logic [15:0] INSTR_NOP   = 16'h0000;
  localparam logic [15:0] INSTR_RESET = 16'h000C;
  localparam logic [15:0] INSTR_BW    = 16'h0007;
  localparam logic [15:0] INSTR_BR    = 16'h0003;
  localparam logic [4:0]  WAIT_LAST   = 5'(OPERATE_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PREAMBLE, S_BW_ISSUE, S_BW_DATA,
    S_OP_ISSUE, S_OP_WAIT, S_BR_ISSUE, S_BR_DATA, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  opnd_q [18];
  logic [7:0]  opnd_d [18];
  logic [7:0]  res_even_q [9];
  logic [7:0]  res_even_d [9];
  logic [7:0]  res_odd_q [9];
  logic [7:0]  res_odd_d [9];

  logic [15:0] instr_hi, instr_lo;
  logic [4:0]  bw_base, bw_idx1, bw_idx2, bw_idx3;
  logic [7:0]  drain_byte;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Buffer contents are don't-care after reset, so these flops carry no reset.
  always_ff @(posedge clock_in) begin
    opnd_q    <= opnd_d;
    res_odd_q <= res_odd_d;
  end

  // Even result bytes are the CPU high-phase values, captured mid-cycle.
  always_ff @(negedge clock_in) begin
    res_even_q <= res_even_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (job_valid_in && job_ready_out) begin
          state_d = S_LOAD;
          op_d    = job_op_in;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (operand_valid_in) begin
          if (cnt_q == 5'd17) begin
            cnt_d = '0;
`ifdef TENSOR_HOST_RESET_PREAMBLE_EN
            state_d = S_PREAMBLE;
`else
            state_d = S_BW_ISSUE;
`endif
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
`ifdef TENSOR_HOST_RESET_PREAMBLE_EN
      S_PREAMBLE: state_d = S_BW_ISSUE;
`endif
      S_BW_ISSUE: begin
        state_d = S_BW_DATA;
        cnt_d   = '0;
      end
      S_BW_DATA: begin
        if (cnt_q == 5'd4) begin
          state_d = S_OP_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_OP_ISSUE: begin
        state_d = S_OP_WAIT;
        cnt_d   = '0;
      end
      S_OP_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_BR_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_BR_ISSUE: begin
        state_d = S_BR_DATA;
        cnt_d   = '0;
      end
      S_BR_DATA: begin
        if (cnt_q == 5'd8) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (result_ready_in) begin
          if (cnt_q == 5'd17) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opnd_d     = opnd_q;
    res_even_d = res_even_q;
    res_odd_d  = res_odd_q;
    if (state_q == S_LOAD && operand_valid_in && cnt_q < 5'd18) begin
      opnd_d[cnt_q] = operand_data_in;
    end
    if (state_q == S_BR_DATA && cnt_q < 5'd9) begin
      res_even_d[cnt_q[3:0]] = cpu_output_in;
      res_odd_d[cnt_q[3:0]]  = cpu_output_in;
    end
  end

  // Burst write cycle c carries bytes 4c..4c+3; indices past the operand buffer read as zero.
  assign bw_base = {cnt_q[2:0], 2'b00};
  assign bw_idx1 = bw_base + 5'd1;
  assign bw_idx2 = bw_base + 5'd2;
  assign bw_idx3 = bw_base + 5'd3;

  assign drain_byte = cnt_q[0] ? res_odd_q[cnt_q[4:1]] : res_even_q[cnt_q[4:1]];

  always_comb begin
    instr_hi          = INSTR_NOP;
    instr_lo          = INSTR_NOP;
    job_ready_out     = (state_q == S_IDLE) && reset_n_in;
    operand_ready_out = (state_q == S_LOAD);
    result_valid_out  = (state_q == S_DRAIN);
    result_data_out   = 8'h00;
    busy_out          = (state_q != S_IDLE);
    case (state_q)
`ifdef TENSOR_HOST_RESET_PREAMBLE_EN
      S_PREAMBLE: instr_hi = INSTR_RESET;
`endif
      S_BW_ISSUE: instr_hi = INSTR_BW;
      S_BW_DATA: begin
        instr_hi = {(bw_base < 5'd18) ? opnd_q[bw_base] : 8'h00,
                    (bw_idx1 < 5'd18) ? opnd_q[bw_idx1] : 8'h00};
        instr_lo = {(bw_idx2 < 5'd18) ? opnd_q[bw_idx2] : 8'h00,
                    (bw_idx3 < 5'd18) ? opnd_q[bw_idx3] : 8'h00};
      end
      S_OP_ISSUE: instr_hi = {11'b0, op_q, 2'b10};
      S_BR_ISSUE: instr_hi = INSTR_BR;
      S_DRAIN:    result_data_out = drain_byte;
      default:    instr_hi = INSTR_NOP;
    endcase
  end

  // Dual-phase output mux: low-phase word is presented while the clock is low.
  assign current_instruction_out = (state_q == S_BW_DATA && !clock_in) ? instr_lo : instr_hi;

endmodule

// File: tb/tb_tensor_host_sequencer.sv
// Directed self-checking bench for tensor_host_sequencer with a small behavioural CPU burst-read responder.
// Honours TENSOR_HOST_RESET_PREAMBLE_EN when the design is built with it.
module tb_tensor_host_sequencer;

  localparam int W = 8;

  logic              clock_in = 1'b0;
  logic              reset_n_in;
  logic              job_valid_in;
  logic [2:0]        job_op_in;
  logic              job_ready_out;
  logic              operand_valid_in;
  logic [7:0]        operand_data_in;
  logic              operand_ready_out;
  logic [15:0]       current_instruction_out;
  logic signed [7:0] cpu_output_in;
  logic              result_valid_out;
  logic [7:0]        result_data_out;
  logic              result_ready_in;
  logic              busy_out;

  int vectors = 0;
  int miscompares = 0;
  int br_r = -1;
  logic br_pending = 1'b0;

  tensor_host_sequencer #(.OPERATE_WAIT(W)) dut (
    .clock_in               (clock_in),
    .reset_n_in             (reset_n_in),
    .job_valid_in           (job_valid_in),
    .job_op_in              (job_op_in),
    .job_ready_out          (job_ready_out),
    .operand_valid_in       (operand_valid_in),
    .operand_data_in        (operand_data_in),
    .operand_ready_out      (operand_ready_out),
    .current_instruction_out(current_instruction_out),
    .cpu_output_in          (cpu_output_in),
    .result_valid_out       (result_valid_out),
    .result_data_out        (result_data_out),
    .result_ready_in        (result_ready_in),
    .busy_out               (busy_out)
  );

  always #5 clock_in = ~clock_in;

  // CPU responder: after seeing a burst read, drives 0x10+2r high phase, 0x11+2r low phase for 9 cycles.
  initial begin
    cpu_output_in = 8'sh00;
    forever begin
      @(posedge clock_in);
      #1;
      if (br_pending) begin
        br_r = 0;
        br_pending = 1'b0;
      end else if (br_r >= 0 && br_r < 8) begin
        br_r = br_r + 1;
      end else begin
        br_r = -1;
      end
      if (br_r >= 0) cpu_output_in = $signed(8'(8'h10 + 2 * br_r));
      @(negedge clock_in);
      #1;
      if (br_r >= 0) cpu_output_in = $signed(8'(8'h11 + 2 * br_r));
      if (current_instruction_out == 16'h0003) br_pending = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Accept a job and stream its 18 operand bytes base, base+1, ...
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] base);
    job_valid_in = 1'b1;
    job_op_in    = op;
    tick();
    job_valid_in = 1'b0;
    checkOutput("load_busy", 16'(busy_out), 16'h1);
    checkOutput("load_operand_ready", 16'(operand_ready_out), 16'h1);
    checkOutput("load_job_ready", 16'(job_ready_out), 16'h0);
    for (int k = 0; k < 18; k++) begin
      operand_valid_in = 1'b1;
      operand_data_in  = 8'(base + k);
      tick();
    end
    operand_valid_in = 1'b0;
  endtask

  task automatic runBurst(input logic [7:0] base, input logic [15:0] op_instr);
    logic [7:0] b0, b1, b2, b3;
`ifdef TENSOR_HOST_RESET_PREAMBLE_EN
    checkOutput("preamble", current_instruction_out, 16'h000C);
    tick();
`endif
    checkOutput("bw_issue", current_instruction_out, 16'h0007);
    checkOutput("operand_ready_off", 16'(operand_ready_out), 16'h0);
    for (int c = 0; c < 5; c++) begin
      b0 = 8'(base + 4 * c);
      b1 = 8'(base + 4 * c + 1);
      b2 = (c == 4) ? 8'h00 : 8'(base + 4 * c + 2);
      b3 = (c == 4) ? 8'h00 : 8'(base + 4 * c + 3);
      tick();
      checkOutput("bw_data_hi", current_instruction_out, {b0, b1});
      @(negedge clock_in);
      #1;
      checkOutput("bw_data_lo", current_instruction_out, {b2, b3});
    end
    tick();
    checkOutput("op_issue", current_instruction_out, op_instr);
    for (int i = 0; i < W; i++) begin
      tick();
      checkOutput("op_wait_nop", current_instruction_out, 16'h0000);
    end
    tick();
    checkOutput("br_issue", current_instruction_out, 16'h0003);
    for (int r = 0; r < 9; r++) begin
      tick();
      checkOutput("br_data_nop", current_instruction_out, 16'h0000);
      checkOutput("br_data_valid", 16'(result_valid_out), 16'h0);
    end
    tick();
  endtask

  // Drain 18 results; backpressure selects the ready pattern 1,0,0,1,0,0...
  task automatic drainResults(input bit backpressure);
    int j = 0;
    int cyc = 0;
    while (j < 18 && cyc < 100) begin
      result_ready_in = !backpressure || (cyc % 3 == 0);
      checkOutput("drain_valid", 16'(result_valid_out), 16'h1);
      checkOutput("drain_data", 16'(result_data_out), 16'(8'h10 + j));
      checkOutput("drain_job_ready", 16'(job_ready_out), 16'h0);
      if (result_ready_in) j++;
      cyc++;
      tick();
    end
    result_ready_in = 1'b0;
    checkOutput("idle_busy", 16'(busy_out), 16'h0);
    checkOutput("idle_result_valid", 16'(result_valid_out), 16'h0);
    checkOutput("idle_job_ready", 16'(job_ready_out), 16'h1);
    checkOutput("idle_data", 16'(result_data_out), 16'h0000);
  endtask

  initial begin
    reset_n_in       = 1'b0;
    job_valid_in     = 1'b1;
    job_op_in        = 3'd0;
    operand_valid_in = 1'b0;
    operand_data_in  = 8'h00;
    result_ready_in  = 1'b0;

    repeat (3) begin
      tick();
      checkOutput("rst_instr", current_instruction_out, 16'h0000);
      checkOutput("rst_job_ready", 16'(job_ready_out), 16'h0);
      checkOutput("rst_operand_ready", 16'(operand_ready_out), 16'h0);
      checkOutput("rst_result_valid", 16'(result_valid_out), 16'h0);
      checkOutput("rst_busy", 16'(busy_out), 16'h0);
      checkOutput("rst_result_data", 16'(result_data_out), 16'h0000);
    end
    reset_n_in   = 1'b1;
    job_valid_in = 1'b0;
    #1;
    checkOutput("post_rst_job_ready", 16'(job_ready_out), 16'h1);
    checkOutput("post_rst_busy", 16'(busy_out), 16'h0);

    $display("[TB] job 1: op=0, operands 0x01..0x12");
    applyStimulus(3'd0, 8'h01);
    runBurst(8'h01, 16'h0002);
    drainResults(1'b0);

    $display("[TB] job 2: op=5, backpressured drain");
    applyStimulus(3'd5, 8'hA0);
    runBurst(8'hA0, 16'h0016);
    drainResults(1'b1);

    $display("[TB] job 3: abort in burst write cycle 2");
    applyStimulus(3'd1, 8'h20);
`ifdef TENSOR_HOST_RESET_PREAMBLE_EN
    tick();
`endif
    tick();
    tick();
    tick();
    checkOutput("abort_c2_hi", current_instruction_out, 16'h2829);
    reset_n_in = 1'b0;
    #1;
    checkOutput("abort_busy", 16'(busy_out), 16'h0);
    checkOutput("abort_instr", current_instruction_out, 16'h0000);
    checkOutput("abort_job_ready", 16'(job_ready_out), 16'h0);
    tick();
    tick();
    reset_n_in = 1'b1;
    #1;
    checkOutput("abort_release_job_ready", 16'(job_ready_out), 16'h1);

    $display("[TB] job 4: op=3 after abort");
    applyStimulus(3'd3, 8'h40);
    runBurst(8'h40, 16'h000E);
    drainResults(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
